// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state type and requester count.
package arb_pkg;

  localparam int unsigned REQ_NUM = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux2x1.sv
// Generic 2:1 multiplexer.
//   sel : 0 selects a, 1 selects b
//   a/b : data inputs, W bits
//   y   : selected data, W bits
module mux2x1 #(
  parameter int unsigned W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one write port between two requesters,
// with a bounded hold time when the other requester is waiting.
//   clk, rst            : clock, synchronous active-high reset
//   req0/req1           : requests, held until granted and done
//   addr*/wdata*/we*    : requester access fields
//   gnt0/gnt1           : registered grants, mutually exclusive
//   sel                 : steering select (0 = req 0, 1 = req 1)
//   mem_addr/wdata/we   : steered port, combinational from sel/busy
//   busy                : a grant is active
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             busy
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  arb_state_t           state, state_nxt;
  logic                 last_served, last_nxt;
  logic [HW-1:0]        hold_cnt, hold_nxt;
  logic                 sel_nxt;
  logic [REQ_NUM-1:0]   req_vec;
  logic                 own_req, other_req;
  arb_state_t           other_st;
  logic                 we_sel;

  assign req_vec = {req1, req0};

  // Next-state, hold counter and round-robin pointer
  always_comb begin
    state_nxt = state;
    last_nxt  = last_served;
    hold_nxt  = hold_cnt;
    sel_nxt   = sel;
    own_req   = 1'b0;
    other_req = 1'b0;
    other_st  = IDLE;

    unique case (state)
      IDLE: begin
        // On a tie, last_served = 1 means requester 0 is next in line
        if (req_vec[0] && (!req_vec[1] || last_served)) begin
          state_nxt = GRANT0;
        end else if (req_vec[1]) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        own_req   = (state == GRANT1) ? req_vec[1] : req_vec[0];
        other_req = (state == GRANT1) ? req_vec[0] : req_vec[1];
        other_st  = (state == GRANT1) ? GRANT0 : GRANT1;
        if (!own_req) begin
          state_nxt = other_req ? other_st : IDLE;
        end else if (other_req && (hold_cnt == HW'(MAX_HOLD - 1))) begin
          state_nxt = other_st;
        end else if (other_req && (hold_cnt != HW'(MAX_HOLD))) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Entering a grant restarts the hold window and records the owner
    if ((state_nxt != state) && (state_nxt != IDLE)) begin
      hold_nxt = '0;
      last_nxt = (state_nxt == GRANT1);
    end
    if (state_nxt == IDLE) begin
      hold_nxt = '0;
    end

    // sel keeps its value through IDLE so the steered port stays stable
    if (state_nxt == GRANT1) begin
      sel_nxt = 1'b1;
    end else if (state_nxt == GRANT0) begin
      sel_nxt = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      hold_cnt    <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      sel         <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      hold_cnt    <= hold_nxt;
      gnt0        <= (state_nxt == GRANT0);
      gnt1        <= (state_nxt == GRANT1);
      busy        <= (state_nxt != IDLE);
      sel         <= sel_nxt;
    end
  end

  mux2x1 #(.W(WIDTH)) u_mux_addr (
    .sel (sel),
    .a   (addr0),
    .b   (addr1),
    .y   (mem_addr)
  );

  mux2x1 #(.W(WIDTH)) u_mux_wdata (
    .sel (sel),
    .a   (wdata0),
    .b   (wdata1),
    .y   (mem_wdata)
  );

  mux2x1 #(.W(1)) u_mux_we (
    .sel (sel),
    .a   (we0),
    .b   (we1),
    .y   (we_sel)
  );

  // No write reaches the port unless a grant is active
  assign mem_we = we_sel & busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter against a behavioural arbiter model.
module tb_mem_port_arbiter;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned MAX_HOLD = 4;

  logic             clk;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;
  logic             we0, we1;
  logic             gnt0, gnt1, sel, busy, mem_we;
  logic [WIDTH-1:0] mem_addr, mem_wdata;

  mem_port_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .we0       (we0),
    .we1       (we1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             g0, g1, sel, busy, we;
    logic [WIDTH-1:0] addr, wdata;
    int               hold;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the port, who went last, how long the
  // competitor has waited in this tenure, and the current steering side.
  int   m_owner;   // -1 = nobody
  int   m_last;
  int   m_wait;
  int   m_sel;

  logic rq[2];
  int   left[2];

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 1;
    m_wait  = 0;
    m_sel   = 0;
  endfunction

  function automatic void model_give(input int who);
    m_owner = who;
    m_last  = who;
    m_wait  = 0;
    m_sel   = who;
  endfunction

  // Apply one clock edge using the request values present at that edge
  function automatic void model_edge();
    int r[2];
    r[0] = int'(req0);
    r[1] = int'(req1);
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (r[0] == 1 && r[1] == 1) model_give(1 - m_last);
      else if (r[0] == 1)         model_give(0);
      else if (r[1] == 1)         model_give(1);
    end else begin
      int me, them;
      me   = m_owner;
      them = 1 - m_owner;
      if (r[me] == 0) begin
        if (r[them] == 1) model_give(them);
        else begin
          m_owner = -1;
          m_wait  = 0;
        end
      end else if (r[them] == 1) begin
        // Competitor has now waited m_wait+1 granted edges
        if (m_wait + 1 >= MAX_HOLD) model_give(them);
        else m_wait = m_wait + 1;
      end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.g0    = (m_owner == 0);
    e.g1    = (m_owner == 1);
    e.busy  = (m_owner >= 0);
    e.sel   = (m_sel == 1);
    e.addr  = (m_sel == 1) ? addr1 : addr0;
    e.wdata = (m_sel == 1) ? wdata1 : wdata0;
    e.we    = e.busy && ((m_sel == 1) ? we1 : we0);
    e.hold  = m_wait;
    expq.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic q0, input logic q1,
                       input logic w0, input logic w1);
    rst    = r;
    req0   = q0;
    req1   = q1;
    we0    = w0;
    we1    = w1;
    addr0  = WIDTH'($urandom);
    addr1  = WIDTH'($urandom);
    wdata0 = WIDTH'($urandom);
    wdata1 = WIDTH'($urandom);
  endtask

  task automatic step(input logic r, input logic q0, input logic q1,
                      input logic w0, input logic w1);
    cycle();
    drive(r, q0, q1, w0, w1);
    push_exp();
  endtask

  // Requesters that hold req until served for a number of granted cycles
  task automatic agent(input int n, input int pct, input int fixlen, input int rst_pct);
    for (int c = 0; c < n; c++) begin
      logic r;
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (rq[i]) begin
          if (m_owner == i) begin
            left[i]--;
            if (left[i] <= 0) rq[i] = 1'b0;
          end
        end else if (int'($urandom_range(99)) < pct) begin
          rq[i]   = 1'b1;
          left[i] = (fixlen > 0) ? fixlen : int'($urandom_range(6, 1));
        end
      end
      r = (int'($urandom_range(99)) < rst_pct);
      drive(r, rq[0], rq[1], 1'($urandom_range(1)), 1'($urandom_range(1)));
      push_exp();
    end
  endtask

  // Monitor: compare every presented cycle away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("gnt0",      int'(gnt0),      int'(e.g0));
        chk("gnt1",      int'(gnt1),      int'(e.g1));
        chk("gnt_excl",  int'(gnt0 & gnt1), 0);
        chk("sel",       int'(sel),       int'(e.sel));
        chk("busy",      int'(busy),      int'(e.busy));
        chk("mem_we",    int'(mem_we),    int'(e.we));
        chk("mem_addr",  int'(mem_addr),  int'(e.addr));
        chk("mem_wdata", int'(mem_wdata), int'(e.wdata));
        chk("hold_cnt",  int'(dut.hold_cnt), e.hold);
      end
    end
  end

  initial begin
    model_reset();
    rq[0] = 1'b0; rq[1] = 1'b0;
    left[0] = 0;  left[1] = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset held with both requesting, then tie goes to requester 0
    step(1, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    repeat (3) step(0, 1, 1, 1, 1);

    // Drain, then single requester 1
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    // Forced handover: req0 held, req1 joins mid-grant
    repeat (3) step(0, 1, 0, 1, 0);
    repeat (12) step(0, 1, 1, 1, 1);

    // Unlimited hold with no competitor
    repeat (20) step(0, 1, 0, 1, 0);

    // Move to GRANT1 and reset mid-grant with a write pending
    repeat (4) step(0, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    repeat (3) step(0, 1, 1, 1, 1);
    repeat (3) step(0, 0, 0, 0, 0);

    // Round-robin with fixed two-cycle tenures, then random traffic
    agent(40, 100, 2, 0);
    rq[0] = 1'b0; rq[1] = 1'b0;
    agent(600, 30, 0, 1);
    agent(300, 60, 12, 0);

    repeat (3) step(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
